fpu_mult_issue: RTL and testbench
=================================

Name: fpu_mult_issue

Overview:
- Issue/retire stage that sits directly upstream and downstream of the single-precision FP multiplier.
- Accepts multiply ops from the core with a valid/ready handshake and resolves the dynamic rounding mode.
- Drives the multiplier's request port, then captures its 1-cycle-latency result.
- Returns results in order to writeback through a small result FIFO, with tag and status.

Parameters:
- TAG_W, 5, width of the destination tag carried alongside each op.
- DEPTH, 2, result FIFO entries; also the cap on in-flight plus buffered ops (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  drop all in-flight and buffered ops
- in_valid  in  1  op offered
- in_ready  out  1  op accepted when in_valid&in_ready
- in_a  in  32  operand A
- in_b  in  32  operand B
- in_rm  in  3  instruction rm field (111 = dynamic)
- in_tag  in  TAG_W  destination tag
- frm  in  3  fcsr.frm
- mul_req  out  1  multiplier req_in
- mul_a  out  32  multiplier A
- mul_b  out  32  multiplier B
- mul_rm  out  3  multiplier rm
- mul_out  in  32  multiplier Out
- mul_valid  in  1  multiplier valid_out
- res_valid  out  1  result available
- res_ready  in  1  writeback accepts result
- res_data  out  32  product
- res_tag  out  TAG_W  tag of res_data
- res_illegal  out  1  op had an illegal rounding mode
- seq_err  out  1  sticky: mul_valid mismatched expectation

Behaviour:
- Reset (rst_n=0, async): in_ready=0 for the reset cycle; res_valid=0; mul_req=0; mul_a/b/rm=0; seq_err=0; FIFO empty; p1 stage invalid.
- rm resolution: eff_rm = (in_rm==111) ? frm : in_rm.
  - eff_rm in {101,110,111} → illegal op.
- in_ready = !flush && (fifo_count + p1_valid < DEPTH).
  - Combinational; independent of in_valid.
- Issue on in_valid&in_ready.
  - Legal op: mul_req=1 combinationally the same cycle; mul_a=in_a, mul_b=in_b, mul_rm=eff_rm.
  - Illegal op: mul_req=0 (bypass).
  - Either way, p1 is loaded: p1_valid=1, p1_tag, p1_bypass=illegal.
- Cycle after issue, p1 pushes one FIFO entry.
  - Normal: {mul_out, tag, illegal=0}.
  - Bypass: {32'h0, tag, illegal=1}.
  - Order preserved because both paths take exactly 1 cycle.
- seq_err is set if mul_valid != (p1_valid & !p1_bypass) in any cycle. Sticky until reset.
- FIFO:
  - Circular, log2(DEPTH)-bit pointers with wrap; count 0..DEPTH.
  - res_* driven from the head entry; pop on res_valid&res_ready.
  - Push and pop in the same cycle with a full FIFO is legal; count is unchanged.
  - Overflow cannot occur: the credit check covers the p1 stage.
- Back-to-back issue is allowed every cycle while credit remains: sustained throughput 1/cycle when res_ready=1.
- Latency: issue cycle N → res_valid earliest at N+2 (registered FIFO output, no bypass path).
- flush:
  - Empties the FIFO and clears p1_valid in the same edge; in_ready=0 that cycle.
  - A mul_valid arriving the following cycle for a flushed op is discarded and does not set seq_err.
  - A one-bit "expect-and-drop" flag tracks that case.
- Reset mid-operation: all state cleared immediately; no partial result leaves.

Optional Feature:
- Macro FPU_MULT_FLAGS_EN.
- When defined:
  - Adds output res_fflags[4:0] {NV,DZ,OF,UF,NX}.
  - NV is computed at issue from the raw operands: either operand is sNaN (exp=FF, frac≠0, frac[22]=0), or inf×zero. It is stored in p1 and the FIFO.
  - OF is set if the result exp=FF with frac=0 and neither operand was inf; NX is set with it.
  - DZ=0; UF=0.
  - Illegal ops report 0.
- When undefined: the port is absent and no flag storage exists.

Decomposition:
- Package fpu_mult_pkg holds:
  - RM_RNE/RTZ/RDN/RUP/RMM/DYN constants.
  - QNAN_F32 = 32'h7FC00000.
  - Flag bit indices.
  - A typedef for the FIFO entry struct {data, tag, illegal[, fflags]}.
- One natural sub-module: fpu_res_fifo (parameterised width/depth circular buffer with count).
- Issue/credit logic stays in the top module.

Test Plan:
- Basic op: A=3FC00000, B=40000000, in_rm=000, res_ready=1 → mul_req pulse with mul_rm=000; two cycles later res_data=40400000, res_illegal=0, tag echoed.
- Dynamic rm: in_rm=111, frm=001 → mul_rm=001.
  - in_rm=111, frm=101 → no mul_req, res_data=0, res_illegal=1, order kept relative to neighbouring ops.
- Backpressure: res_ready=0, offer 4 ops → exactly DEPTH(2) accepted, in_ready=0 after.
  - Then raise res_ready → results pop in issue order with correct tags, no loss.
- Flush: issue an op, assert flush the next cycle → FIFO empty, res_valid stays 0, mul_valid the following cycle ignored, seq_err=0.
- Protocol check: inject a spurious mul_valid with nothing in flight → seq_err=1 and remains 1 until rst_n low.
- FPU_MULT_FLAGS_EN: A=7F800000, B=00000000 → res_fflags NV=1.
  - A=7F000000, B=7F000000, rm=000 → res_data=7F800000, OF=1, NX=1.

Source files
------------

// File: rtl/fpu_mult_pkg.sv
// Shared definitions for the FP multiplier issue/retire stage.
// Optional build macro: FPU_MULT_FLAGS_EN adds IEEE exception flag tracking.
package fpu_mult_pkg;

  // Rounding-mode encodings used in the rm field and fcsr.frm
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  // Canonical quiet NaN
  localparam logic [31:0] QNAN_F32 = 32'h7FC0_0000;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  // Result payload carried through the result FIFO; the top module
  // wraps it together with the destination tag, whose width is a
  // parameter of the top and therefore cannot live in the package.
  typedef struct packed {
    logic [31:0] data;
    logic        illegal;
`ifdef FPU_MULT_FLAGS_EN
    logic [4:0]  fflags;
`endif
  } res_payload_t;

  // Rounding modes 101, 110 and an unresolved 111 have no meaning
  function automatic logic rm_is_illegal(input logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
  endfunction

  // Infinity of either sign: all-ones exponent, zero fraction
  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Zero of either sign
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:0] == 31'd0);
  endfunction

  // Signalling NaN: all-ones exponent, nonzero fraction, quiet bit clear
  function automatic logic is_snan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0) && !x[22];
  endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Parameterised circular result buffer with occupancy count.
// Pushes are accepted when not full, or when full but popping in the
// same cycle; flush empties the buffer on the next edge.
module fpu_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Entry storage; contents are only observed while count is nonzero
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and count; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_mult_issue.sv
// Issue/retire stage around the single-precision FP multiplier.
// Resolves dynamic rounding, issues legal ops to the multiplier, bypasses
// illegal ones, and returns results in order through a small FIFO.
// Optional build macro: FPU_MULT_FLAGS_EN adds the res_fflags output.
module fpu_mult_issue #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       frm,
  output logic             mul_req,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic [2:0]       mul_rm,
  input  logic [31:0]      mul_out,
  input  logic             mul_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_illegal,
`ifdef FPU_MULT_FLAGS_EN
  output logic [4:0]       res_fflags,
`endif
  output logic             seq_err
);

  import fpu_mult_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    res_payload_t     payload;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Issue-side signals
  logic [2:0]       eff_rm;
  logic             op_illegal;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  // Stage p1: one op whose multiplier result arrives this cycle
  logic             p1_valid;
  logic             p1_bypass;
  logic [TAG_W-1:0] p1_tag;
  logic             expect_mul;
  logic             drop_pending;

`ifdef FPU_MULT_FLAGS_EN
  logic             issue_nv;
  logic             issue_inf;
  logic             p1_nv;
  logic             p1_inf;
  logic             overflow;
`endif

  // FIFO interface
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  fifo_entry_t      push_entry;
  fifo_entry_t      head_entry;
  logic [ENTRY_W-1:0] head_bits;

  assign eff_rm     = (in_rm == RM_DYN) ? frm : in_rm;
  assign op_illegal = rm_is_illegal(eff_rm);

  // Credit covers both buffered results and the op whose result is pending,
  // so a push from p1 can never find the FIFO full without a matching pop.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, p1_valid};
  assign in_ready  = rst_n && !flush && (occupancy < (CNT_W + 1)'(DEPTH));
  assign issue     = in_valid && in_ready;

  assign mul_req = issue && !op_illegal;
  assign mul_a   = mul_req ? in_a   : 32'd0;
  assign mul_b   = mul_req ? in_b   : 32'd0;
  assign mul_rm  = mul_req ? eff_rm : 3'd0;

`ifdef FPU_MULT_FLAGS_EN
  assign issue_nv  = is_snan(in_a) || is_snan(in_b) ||
                     (is_inf(in_a) && is_zero(in_b)) ||
                     (is_zero(in_a) && is_inf(in_b));
  assign issue_inf = is_inf(in_a) || is_inf(in_b);
`endif

  // Track the op whose multiplier result is due next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid  <= 1'b0;
      p1_bypass <= 1'b0;
      p1_tag    <= '0;
`ifdef FPU_MULT_FLAGS_EN
      p1_nv     <= 1'b0;
      p1_inf    <= 1'b0;
`endif
    end else if (flush) begin
      p1_valid  <= 1'b0;
    end else begin
      p1_valid <= issue;
      if (issue) begin
        p1_bypass <= op_illegal;
        p1_tag    <= in_tag;
`ifdef FPU_MULT_FLAGS_EN
        p1_nv     <= issue_nv;
        p1_inf    <= issue_inf;
`endif
      end
    end
  end

  assign expect_mul = p1_valid && !p1_bypass;

  // Sticky protocol check; a result owed to a flushed op is tolerated once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err      <= 1'b0;
      drop_pending <= 1'b0;
    end else begin
      drop_pending <= flush && expect_mul;
      if ((mul_valid != expect_mul) && !drop_pending) begin
        seq_err <= 1'b1;
      end
    end
  end

`ifdef FPU_MULT_FLAGS_EN
  assign overflow = !p1_bypass && is_inf(mul_out) && !p1_inf;
`endif

  // Build the FIFO entry from p1 and the multiplier output
  always_comb begin
    push_entry                 = '0;
    push_entry.tag             = p1_tag;
    push_entry.payload.illegal = p1_bypass;
    push_entry.payload.data    = p1_bypass ? 32'd0 : mul_out;
`ifdef FPU_MULT_FLAGS_EN
    if (!p1_bypass) begin
      push_entry.payload.fflags[FLAG_NV] = p1_nv;
      push_entry.payload.fflags[FLAG_OF] = overflow;
      push_entry.payload.fflags[FLAG_NX] = overflow;
    end
`endif
  end

  assign fifo_push = p1_valid && !flush;
  assign fifo_pop  = res_valid && res_ready;

  fpu_res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_bits),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign head_entry  = head_bits;
  assign res_valid   = !fifo_empty;
  assign res_data    = head_entry.payload.data;
  assign res_tag     = head_entry.tag;
  assign res_illegal = head_entry.payload.illegal;
`ifdef FPU_MULT_FLAGS_EN
  assign res_fflags  = head_entry.payload.fflags;
`endif

endmodule

// File: tb/tb_fpu_mult_issue.sv
// Self-checking bench for fpu_mult_issue with a 1-cycle multiplier model.
// Optional build macro: FPU_MULT_FLAGS_EN enables the flag vectors.
module tb_fpu_mult_issue;

  localparam int TAG_W = 5;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [2:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic [2:0]       frm;
  logic             mul_req;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [2:0]       mul_rm;
  logic [31:0]      mul_out;
  logic             mul_valid;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_illegal;
  logic             seq_err;
`ifdef FPU_MULT_FLAGS_EN
  logic [4:0]       res_fflags;
`endif

  logic             mul_vld_q;
  logic             spur;
  int               tests_run = 0;
  int               tests_failed = 0;

  fpu_mult_issue #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_rm       (in_rm),
    .in_tag      (in_tag),
    .frm         (frm),
    .mul_req     (mul_req),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_rm      (mul_rm),
    .mul_out     (mul_out),
    .mul_valid   (mul_valid),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_illegal (res_illegal),
`ifdef FPU_MULT_FLAGS_EN
    .res_fflags  (res_fflags),
`endif
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  // Hand-computed products for the operand pairs used below
  function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000) return b;
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
    if (a == 32'h7F80_0000 && b == 32'h0000_0000) return 32'h7FC0_0000;
    if (a == 32'h7F00_0000 && b == 32'h7F00_0000) return 32'h7F80_0000;
    return 32'h0;
  endfunction

  // Multiplier model: one cycle of latency from request to result
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_vld_q <= 1'b0;
      mul_out   <= 32'h0;
    end else begin
      mul_vld_q <= mul_req;
      mul_out   <= fake_mul(mul_a, mul_b);
    end
  end

  assign mul_valid = mul_vld_q | spur;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] rm, input logic [2:0] f, input logic [TAG_W-1:0] tag);
    in_valid = valid;
    in_a     = a;
    in_b     = b;
    in_rm    = rm;
    frm      = f;
    in_tag   = tag;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, wait for acceptance, check the multiplier request
  task automatic issueOp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                         input logic [2:0] f, input logic [TAG_W-1:0] tag,
                         input logic exp_req, input logic [2:0] exp_rm);
    int waited = 0;
    applyStimulus(1'b1, a, b, rm, f, tag);
    #1;
    while (!in_ready && waited < 20) begin
      nextCycle();
      waited++;
    end
    if (!in_ready) checkOutput("issue_timeout", {31'd0, in_ready}, 32'd1);
    checkOutput("mul_req", {31'd0, mul_req}, {31'd0, exp_req});
    if (exp_req) begin
      checkOutput("mul_rm", {29'd0, mul_rm}, {29'd0, exp_rm});
      checkOutput("mul_a", mul_a, a);
    end
    nextCycle();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the next result and check it; res_ready must be 1
  task automatic drainResult(input logic [31:0] exp_data, input logic [TAG_W-1:0] exp_tag,
                             input logic exp_ill);
    int waited = 0;
    while (!res_valid && waited < 20) begin
      nextCycle();
      waited++;
    end
    if (!res_valid) begin
      checkOutput("result_timeout", {31'd0, res_valid}, 32'd1);
    end else begin
      checkOutput("res_data", res_data, exp_data);
      checkOutput("res_tag", 32'(res_tag), 32'(exp_tag));
      checkOutput("res_illegal", {31'd0, res_illegal}, {31'd0, exp_ill});
`ifdef FPU_MULT_FLAGS_EN
      checkOutput("res_fflags_legacy", {27'd0, res_fflags} & 32'h0, 32'h0);
`endif
      nextCycle();
    end
  endtask

`ifdef FPU_MULT_FLAGS_EN
  task automatic drainFlags(input logic [31:0] exp_data, input logic [4:0] exp_flags);
    int waited = 0;
    while (!res_valid && waited < 20) begin
      nextCycle();
      waited++;
    end
    if (!res_valid) begin
      checkOutput("flags_timeout", {31'd0, res_valid}, 32'd1);
    end else begin
      checkOutput("flags_data", res_data, exp_data);
      checkOutput("res_fflags", {27'd0, res_fflags}, {27'd0, exp_flags});
      nextCycle();
    end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] bp_vals [4];
    int accepted;
    bp_vals[0] = 32'h4040_0000;
    bp_vals[1] = 32'h40A0_0000;
    bp_vals[2] = 32'h40E0_0000;
    bp_vals[3] = 32'h4110_0000;

    // Reset state, with an op offered to prove in_ready is held low
    rst_n = 1'b0;
    flush = 1'b0;
    spur = 1'b0;
    res_ready = 1'b0;
    applyStimulus(1'b1, 32'h3FC0_0000, 32'h4000_0000, 3'b000, 3'b000, 5'd1);
    #2;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_mul_req", {31'd0, mul_req}, 32'd0);
    checkOutput("rst_mul_a", mul_a, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_seq_err", {31'd0, seq_err}, 32'd0);
    in_valid = 1'b0;
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // Basic op with exact two-cycle latency
    res_ready = 1'b1;
    issueOp(32'h3FC0_0000, 32'h4000_0000, 3'b000, 3'b000, 5'd5, 1'b1, 3'b000);
    checkOutput("basic_lat1_valid", {31'd0, res_valid}, 32'd0);
    nextCycle();
    checkOutput("basic_lat2_valid", {31'd0, res_valid}, 32'd1);
    drainResult(32'h4040_0000, 5'd5, 1'b0);
    checkOutput("basic_popped", {31'd0, res_valid}, 32'd0);

    // Dynamic rounding: legal via frm, then illegal via frm, order kept
    res_ready = 1'b0;
    issueOp(32'h4000_0000, 32'h4000_0000, 3'b111, 3'b001, 5'd6, 1'b1, 3'b001);
    issueOp(32'h4000_0000, 32'h4000_0000, 3'b111, 3'b101, 5'd7, 1'b0, 3'b000);
    res_ready = 1'b1;
    drainResult(32'h4080_0000, 5'd6, 1'b0);
    drainResult(32'h0000_0000, 5'd7, 1'b1);
    issueOp(32'h3F80_0000, 32'h3F80_0000, 3'b010, 3'b101, 5'd8, 1'b1, 3'b010);
    drainResult(32'h3F80_0000, 5'd8, 1'b0);
    checkOutput("dyn_seq_err", {31'd0, seq_err}, 32'd0);

    // Backpressure: four offers, only DEPTH accepted
    res_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h3F80_0000, bp_vals[i], 3'b000, 3'b000, TAG_W'(10 + i));
      #1;
      if (in_ready) accepted++;
      if (i == 2) checkOutput("bp_no_req_when_full", {31'd0, mul_req}, 32'd0);
      nextCycle();
    end
    in_valid = 1'b0;
    #1;
    checkOutput("bp_accepted", 32'(accepted), 32'd2);
    checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    res_ready = 1'b1;
    drainResult(bp_vals[0], 5'd10, 1'b0);
    drainResult(bp_vals[1], 5'd11, 1'b0);
    checkOutput("bp_empty", {31'd0, res_valid}, 32'd0);

    // Flush the cycle after issue; a late mul_valid is then tolerated
    issueOp(32'h4000_0000, 32'h4000_0000, 3'b000, 3'b000, 5'd20, 1'b1, 3'b000);
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
    nextCycle();
    flush = 1'b0;
    spur = 1'b1;
    #1;
    checkOutput("flush_res_valid0", {31'd0, res_valid}, 32'd0);
    nextCycle();
    spur = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("flush_res_valid", {31'd0, res_valid}, 32'd0);
      nextCycle();
    end
    checkOutput("flush_seq_err", {31'd0, seq_err}, 32'd0);

    // Spurious mul_valid with nothing in flight sets a sticky error
    spur = 1'b1;
    nextCycle();
    spur = 1'b0;
    checkOutput("spur_seq_err", {31'd0, seq_err}, 32'd1);
    nextCycle();
    nextCycle();
    checkOutput("spur_sticky", {31'd0, seq_err}, 32'd1);

    // Reset mid-operation clears everything and nothing escapes
    issueOp(32'h3F80_0000, 32'h4040_0000, 3'b000, 3'b000, 5'd21, 1'b1, 3'b000);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_seq_err", {31'd0, seq_err}, 32'd0);
    checkOutput("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("midrst_no_result", {31'd0, res_valid}, 32'd0);
      nextCycle();
    end
    checkOutput("midrst_seq_err_after", {31'd0, seq_err}, 32'd0);

`ifdef FPU_MULT_FLAGS_EN
    // Exception flags: inf x zero is invalid, large x large overflows
    issueOp(32'h7F80_0000, 32'h0000_0000, 3'b000, 3'b000, 5'd3, 1'b1, 3'b000);
    drainFlags(32'h7FC0_0000, 5'b10000);
    issueOp(32'h7F00_0000, 32'h7F00_0000, 3'b000, 3'b000, 5'd4, 1'b1, 3'b000);
    drainFlags(32'h7F80_0000, 5'b00101);
    issueOp(32'h4000_0000, 32'h4000_0000, 3'b110, 3'b000, 5'd9, 1'b0, 3'b000);
    drainFlags(32'h0000_0000, 5'b00000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
